// File: rtl/alu_pkg.sv
// Shared encodings for the ID->EX issue path: ALU op codes, ALUOp values,
// R-type funct codes and I-type opcodes.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [OP_W-1:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_ANDI = 6'b001100;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_SLTI = 6'b001010;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct/opcode decode into the ALU operation code.
// Undecodable funct or opcode yields NOP and flags illegal.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0]      alu_ctrl,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  output logic [OP_W-1:0] op,
  output logic            illegal
);

  always_comb begin
    op      = ALU_NOP;
    illegal = 1'b0;
    case (aluop_e'(alu_ctrl))
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  op = ALU_ADD;
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_ITYPE: begin
        case (opcode)
          OPC_ADDI: op = ALU_ADD;
          OPC_ANDI: op = ALU_AND;
          OPC_ORI:  op = ALU_OR;
          OPC_SLTI: op = ALU_SLT;
          default:  illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the ALU operation, selects operands and holds
// them in a 2-entry skid buffer (main drives the outputs, skid absorbs stalls).
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_ctrl,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              illegal
);

  import alu_pkg::*;

  // Stage p0: decode and operand select on the incoming entry
  logic [OP_W-1:0]   op_p0;
  logic              ill_p0;
  logic [DATA_W-1:0] b_p0;

  alu_op_decode u_decode (
    .alu_ctrl (alu_ctrl),
    .opcode   (opcode),
    .funct    (funct),
    .op       (op_p0),
    .illegal  (ill_p0)
  );

  assign b_p0 = alu_src ? imm : rt_val;

  logic accept, emit;
  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  logic [1:0] cnt, cnt_nxt;
  logic       load_main_in, load_main_skid, load_skid;

  always_comb begin
    cnt_nxt        = cnt;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (cnt)
      2'd0: if (accept) begin
        cnt_nxt      = 2'd1;
        load_main_in = 1'b1;
      end
      2'd1: begin
        if (accept && emit) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          cnt_nxt   = 2'd2;
          load_skid = 1'b1;
        end else if (emit) begin
          cnt_nxt = 2'd0;
        end
      end
      2'd2: if (emit) begin
        cnt_nxt        = 2'd1;
        load_main_skid = 1'b1;
      end
      default: cnt_nxt = 2'd0;
    endcase
    if (flush) begin
      cnt_nxt        = 2'd0;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Stage p1: occupancy control; in_ready/out_valid are registered from next count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      in_ready  <= (cnt_nxt != 2'd2);
      out_valid <= (cnt_nxt != 2'd0);
    end
  end

  logic [OP_W-1:0]   skid_op_p1;
  logic [DATA_W-1:0] skid_a_p1, skid_b_p1;
  logic              skid_ill_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op  <= ALU_NOP;
      alu_a   <= '0;
      alu_b   <= '0;
      illegal <= 1'b0;
    end else if (load_main_in) begin
      alu_op  <= op_p0;
      alu_a   <= rs_val;
      alu_b   <= b_p0;
      illegal <= ill_p0;
    end else if (load_main_skid) begin
      alu_op  <= skid_op_p1;
      alu_a   <= skid_a_p1;
      alu_b   <= skid_b_p1;
      illegal <= skid_ill_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid && !rst) begin
      skid_op_p1  <= op_p0;
      skid_a_p1   <= rs_val;
      skid_b_p1   <= b_p0;
      skid_ill_p1 <= ill_p0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// all compared against a queue-based model of the issue buffer.
module tb_alu_issue_stage;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic              clk = 1'b0;
  logic              rst, in_valid, alu_src, flush, out_ready;
  logic              in_ready, out_valid, illegal;
  logic [1:0]        alu_ctrl;
  logic [5:0]        opcode, funct;
  logic [DATA_W-1:0] rs_val, rt_val, imm, alu_a, alu_b;
  logic [OP_W-1:0]   alu_op;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .opcode(opcode), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .alu_src(alu_src),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // What the ALU should be told to do for the instruction currently offered.
  function automatic ent_t ref_entry();
    ent_t e;
    e.op  = 4'b1111;
    e.ill = 1'b0;
    e.a   = rs_val;
    e.b   = alu_src ? imm : rt_val;
    if (alu_ctrl == 2'd0) e.op = 4'b0010;
    else if (alu_ctrl == 2'd1) e.op = 4'b0110;
    else if (alu_ctrl == 2'd2) begin
      if      (funct == 6'd32) e.op = 4'b0010;
      else if (funct == 6'd34) e.op = 4'b0110;
      else if (funct == 6'd36) e.op = 4'b0000;
      else if (funct == 6'd37) e.op = 4'b0001;
      else if (funct == 6'd42) e.op = 4'b0111;
      else e.ill = 1'b1;
    end else begin
      if      (opcode == 6'd8)  e.op = 4'b0010;
      else if (opcode == 6'd12) e.op = 4'b0000;
      else if (opcode == 6'd13) e.op = 4'b0001;
      else if (opcode == 6'd10) e.op = 4'b0111;
      else e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    bit   acc, emt, was_rst;
    ent_t e;
    acc     = in_valid && (q.size() < 2);
    emt     = out_ready && (q.size() > 0);
    was_rst = rst;
    e       = ref_entry();
    @(posedge clk);
    #1;
    if (rst || flush) q.delete();
    else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      check("alu_op", alu_op, q[0].op);
      check("alu_a", alu_a, q[0].a);
      check("alu_b", alu_b, q[0].b);
      check("illegal", illegal, q[0].ill);
    end else if (was_rst) begin
      check("rst_alu_op", alu_op, 4'b1111);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_illegal", illegal, 0);
    end
  endtask

  task automatic offer(input logic [1:0] c, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
                       input logic src);
    in_valid = 1'b1; alu_ctrl = c; opcode = opc; funct = fn;
    rs_val = rs; rt_val = rt; imm = im; alu_src = src;
  endtask

  logic [5:0] fn_tab [5];
  logic [5:0] opc_tab [4];

  initial begin
    fn_tab[0] = 6'd32; fn_tab[1] = 6'd34; fn_tab[2] = 6'd36; fn_tab[3] = 6'd37; fn_tab[4] = 6'd42;
    opc_tab[0] = 6'd8; opc_tab[1] = 6'd12; opc_tab[2] = 6'd13; opc_tab[3] = 6'd10;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 2'd0; opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0; alu_src = 1'b0;
    step();
    step();
    rst = 1'b0;

    // SLT via funct
    out_ready = 1'b1;
    offer(2'b10, 6'd0, 6'b101010, 32'd5, 32'd9, 32'd77, 1'b0);
    step();
    check("slt_op", alu_op, 4'b0111);
    check("slt_a", alu_a, 32'd5);
    check("slt_b", alu_b, 32'd9);
    // ORI with immediate
    offer(2'b11, 6'b001101, 6'd0, 32'd1, 32'd2, 32'h0000FFFF, 1'b1);
    step();
    check("ori_op", alu_op, 4'b0001);
    check("ori_b", alu_b, 32'h0000FFFF);
    // undecodable funct
    offer(2'b10, 6'd0, 6'b111111, 32'd3, 32'd4, 32'd0, 1'b0);
    step();
    check("bad_fn_op", alu_op, 4'b1111);
    check("bad_fn_ill", illegal, 1'b1);
    in_valid = 1'b0;
    step();

    // backpressure: A, B, C offered while stalled
    out_ready = 1'b0;
    offer(2'b00, 6'd0, 6'd0, 32'hA, 32'h1, 32'h0, 1'b0);
    step();
    offer(2'b01, 6'd0, 6'd0, 32'hB, 32'h2, 32'h0, 1'b0);
    step();
    check("bp_full_ready", in_ready, 1'b0);
    offer(2'b10, 6'd0, 6'd37, 32'hC, 32'h3, 32'h0, 1'b0);
    step();
    check("bp_hold_a", alu_a, 32'hA);
    step();
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    check("bp_last_c", alu_a, 32'hC);
    step();

    // streaming rs = 1..8
    for (int i = 1; i <= 8; i++) begin
      offer(2'b00, 6'd0, 6'd0, i, 32'd100 + i, 32'd0, 1'b0);
      step();
      check("stream_rs", alu_a, i);
    end
    in_valid = 1'b0;
    step();

    // flush with full buffer and a valid input
    out_ready = 1'b0;
    offer(2'b00, 6'd0, 6'd0, 32'h11, 32'h0, 32'h0, 1'b0);
    step();
    offer(2'b00, 6'd0, 6'd0, 32'h22, 32'h0, 32'h0, 1'b0);
    step();
    offer(2'b00, 6'd0, 6'd0, 32'h33, 32'h0, 32'h0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    offer(2'b00, 6'd0, 6'd0, 32'h44, 32'h0, 32'h0, 1'b0);
    step();
    check("after_flush_a", alu_a, 32'h44);
    in_valid = 1'b0;
    step();

    // reset while full, then reset together with flush
    out_ready = 1'b0;
    offer(2'b01, 6'd0, 6'd0, 32'h55, 32'h6, 32'h0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_full_op", alu_op, 4'b1111);
    step();
    step();
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      alu_ctrl  = 2'($urandom_range(0, 3));
      funct     = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 4)] : 6'($urandom);
      opcode    = ($urandom_range(0, 3) != 0) ? opc_tab[$urandom_range(0, 3)] : 6'($urandom);
      rs_val    = $urandom;
      rt_val    = $urandom;
      imm       = $urandom;
      alu_src   = 1'($urandom);
      step();
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
